// File: rtl/sfx_scheduler_if.sv
// Request/tone bus between the game-event side and the sound-effect scheduler.
// The master raises effect requests and mute; the slave (scheduler) drives the
// tone path and status back.
interface sfx_scheduler_if #(
    parameter int DIV_W = 22
);
    logic [3:0]       req;
    logic             mute;
    logic [DIV_W-1:0] note_div;
    logic [2:0]       volume;
    logic             busy;
    logic [1:0]       active_id;
    logic             done;

    modport master (
        output req,
        output mute,
        input  note_div,
        input  volume,
        input  busy,
        input  active_id,
        input  done
    );

    modport slave (
        input  req,
        input  mute,
        output note_div,
        output volume,
        output busy,
        output active_id,
        output done
    );
endinterface

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: owns the single tone generator path and plays short
// fixed tone sequences from an internal ROM on behalf of four requesters,
// arbitrating by fixed priority with preemption (higher or equal ID wins).
module sfx_scheduler #(
    parameter int TICK_CYCLES = 5_000_000,
    parameter int DIV_W       = 22
) (
    input logic       clk,
    input logic       rst,
    sfx_scheduler_if.slave bus
);
    localparam int               CYC_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(TICK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_SILENT = '1;

    typedef enum logic {IDLE, PLAY} state_t;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [2:0]       vol;
    } tone_t;

    // Tone part of the effect ROM, indexed by {id, step}; unused slots are silent.
    function automatic tone_t rom_tone(input logic [1:0] id, input logic [1:0] step);
        tone_t t;
        t = '{DIV_SILENT, 3'd0};
        case ({id, step})
            4'b00_00: t = '{DIV_W'(113636), 3'd4};
            4'b01_00: t = '{DIV_W'(56818),  3'd4};
            4'b10_00: t = '{DIV_W'(75757),  3'd3};
            4'b10_01: t = '{DIV_SILENT,     3'd0};
            4'b10_10: t = '{DIV_W'(75757),  3'd3};
            4'b11_00: t = '{DIV_W'(95419),  3'd5};
            4'b11_01: t = '{DIV_W'(75757),  3'd5};
            4'b11_10: t = '{DIV_W'(63775),  3'd5};
            default:  t = '{DIV_SILENT, 3'd0};
        endcase
        return t;
    endfunction

    // Duration part of the effect ROM in ticks; unused slots last one tick.
    function automatic logic [3:0] rom_ticks(input logic [1:0] id, input logic [1:0] step);
        logic [3:0] n;
        n = 4'd1;
        case ({id, step})
            4'b00_00: n = 4'd3;
            4'b01_00: n = 4'd12;
            4'b10_00: n = 4'd2;
            4'b10_01: n = 4'd1;
            4'b10_10: n = 4'd2;
            4'b11_00: n = 4'd4;
            4'b11_01: n = 4'd4;
            4'b11_10: n = 4'd8;
            default:  n = 4'd1;
        endcase
        return n;
    endfunction

    // Index of the final step of each effect.
    function automatic logic [1:0] last_step(input logic [1:0] id);
        return (id[1]) ? 2'd2 : 2'd0;
    endfunction

    state_t           state_reg, state_next;
    logic [CYC_W-1:0] cyc_cnt_reg, cyc_cnt_next;
    logic [3:0]       tick_cnt_reg, tick_cnt_next;
    logic [1:0]       step_idx_reg, step_idx_next;
    logic [1:0]       active_id_reg, active_id_next;
    logic [DIV_W-1:0] note_div_reg, note_div_next;
    logic [2:0]       volume_reg, volume_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [1:0] cand;
    logic       req_any;
    logic       tick_end;
    logic       step_end;
    logic       finish;
    logic       start;
    tone_t      out_tone;

    // Priority encoder: only the highest requested ID is considered.
    always_comb begin
        cand = 2'd0;
        casez (bus.req)
            4'b1???: cand = 2'd3;
            4'b01??: cand = 2'd2;
            4'b001?: cand = 2'd1;
            default: cand = 2'd0;
        endcase
    end

    // State and registered outputs; reset silences the path immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cyc_cnt_reg   <= '0;
            tick_cnt_reg  <= '0;
            step_idx_reg  <= '0;
            active_id_reg <= '0;
            note_div_reg  <= DIV_SILENT;
            volume_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cyc_cnt_reg   <= cyc_cnt_next;
            tick_cnt_reg  <= tick_cnt_next;
            step_idx_reg  <= step_idx_next;
            active_id_reg <= active_id_next;
            note_div_reg  <= note_div_next;
            volume_reg    <= volume_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Next state: arbitration, tick counting and step sequencing. A request on
    // the completion edge is a fresh start even if its ID is lower.
    always_comb begin
        req_any  = |bus.req;
        tick_end = (state_reg == PLAY) && (cyc_cnt_reg == CYC_LAST);
        step_end = tick_end && (tick_cnt_reg == 4'd1);
        finish   = step_end && (step_idx_reg == last_step(active_id_reg));
        start    = req_any && ((state_reg == IDLE) || finish || (cand >= active_id_reg));

        state_next     = state_reg;
        cyc_cnt_next   = cyc_cnt_reg;
        tick_cnt_next  = tick_cnt_reg;
        step_idx_next  = step_idx_reg;
        active_id_next = active_id_reg;

        if (state_reg == PLAY) begin
            cyc_cnt_next = tick_end ? '0 : cyc_cnt_reg + 1'b1;
        end

        if (start) begin
            state_next     = PLAY;
            active_id_next = cand;
            step_idx_next  = 2'd0;
            cyc_cnt_next   = '0;
            tick_cnt_next  = rom_ticks(cand, 2'd0);
        end else if (finish) begin
            state_next    = IDLE;
            step_idx_next = 2'd0;
            tick_cnt_next = '0;
            cyc_cnt_next  = '0;
        end else if (step_end) begin
            step_idx_next = step_idx_reg + 2'd1;
            tick_cnt_next = rom_ticks(active_id_reg, step_idx_reg + 2'd1);
        end else if (tick_end) begin
            tick_cnt_next = tick_cnt_reg - 4'd1;
        end
    end

    // Output values to register: ROM tone of the step being entered, mute gating volume.
    always_comb begin
        out_tone    = rom_tone(active_id_next, step_idx_next);
        note_div_next = DIV_SILENT;
        volume_next   = 3'd0;
        busy_next     = 1'b0;
        done_next     = finish;
        if (state_next == PLAY) begin
            note_div_next = out_tone.div;
            volume_next   = bus.mute ? 3'd0 : out_tone.vol;
            busy_next     = 1'b1;
        end
    end

    assign bus.note_div  = note_div_reg;
    assign bus.volume    = volume_reg;
    assign bus.busy      = busy_reg;
    assign bus.active_id = active_id_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios followed by random requests,
// mute and resets. A time-based reference model pushes the expected output
// for each edge into a scoreboard; a monitor pops and compares on the falling edge.
module tb_sfx_scheduler;
    localparam int TICK = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sfx_scheduler_if #(.DIV_W(22)) bus ();

    sfx_scheduler #(.TICK_CYCLES(TICK), .DIV_W(22)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Effect table as plain data: per effect, per step tone and length in ticks.
    int          t_nsteps [4]    = '{1, 1, 3, 3};
    int          t_ticks  [4][3] = '{'{3, 0, 0}, '{12, 0, 0}, '{2, 1, 2}, '{4, 4, 8}};
    logic [21:0] t_div    [4][3] = '{'{22'd113636, 22'h3FFFFF, 22'h3FFFFF},
                                     '{22'd56818,  22'h3FFFFF, 22'h3FFFFF},
                                     '{22'd75757,  22'h3FFFFF, 22'd75757},
                                     '{22'd95419,  22'd75757,  22'd63775}};
    int          t_vol    [4][3] = '{'{4, 0, 0}, '{4, 0, 0}, '{3, 0, 3}, '{5, 5, 5}};

    typedef struct {
        int          edge_no;
        logic [21:0] div;
        logic [2:0]  vol;
        logic        busy;
        logic [1:0]  aid;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    // Model state: which effect is playing and when it started.
    bit m_play  = 1'b0;
    int m_id    = 0;
    int m_start = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int total_cycles(input int id);
        int s = 0;
        for (int k = 0; k < t_nsteps[id]; k++) s += t_ticks[id][k] * TICK;
        return s;
    endfunction

    // Expected outputs after edge e given the inputs sampled at that edge.
    task automatic model_edge(input logic [3:0] r, input logic m, input logic rs, input int e);
        exp_t x;
        int   cand;
        int   el;
        int   acc;
        x.edge_no = e;
        x.done    = 1'b0;
        if (rs) begin
            m_play = 1'b0;
            m_id   = 0;
        end else begin
            if (m_play && (e - m_start) == total_cycles(m_id)) begin
                m_play = 1'b0;
                x.done = 1'b1;
            end
            if (r != 4'd0) begin
                cand = r[3] ? 3 : r[2] ? 2 : r[1] ? 1 : 0;
                if (!m_play || cand >= m_id) begin
                    m_play  = 1'b1;
                    m_id    = cand;
                    m_start = e;
                end
            end
        end
        x.busy = m_play;
        x.aid  = 2'(m_id);
        x.div  = 22'h3FFFFF;
        x.vol  = 3'd0;
        if (m_play) begin
            el  = e - m_start;
            acc = 0;
            for (int k = 0; k < t_nsteps[m_id]; k++) begin
                if (el >= acc && el < acc + t_ticks[m_id][k] * TICK) begin
                    x.div = t_div[m_id][k];
                    x.vol = m ? 3'd0 : 3'(t_vol[m_id][k]);
                end
                acc += t_ticks[m_id][k] * TICK;
            end
        end
        sb.push_back(x);
    endtask

    task automatic drive(input logic [3:0] r, input logic m, input logic rs);
        @(negedge clk);
        bus.req  = r;
        bus.mute = m;
        rst      = rs;
        if (r != 4'd0 && !rs)
            $display("edge=%0d req=%b mute=%0b", edge_cnt + 1, r, m);
        if (rs)
            $display("edge=%0d reset", edge_cnt + 1);
        model_edge(r, m, rs, edge_cnt + 1);
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) drive(4'd0, m, 1'b0);
    endtask

    // Monitor: compares every expected entry whose edge has already occurred.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (bus.note_div !== x.div || bus.volume !== x.vol || bus.busy !== x.busy ||
                bus.active_id !== x.aid || bus.done !== x.done) begin
                failures++;
                $display("FAIL cycle_out edge=%0d got div=%h vol=%0d busy=%b id=%0d done=%b want div=%h vol=%0d busy=%b id=%0d done=%b",
                         x.edge_no, bus.note_div, bus.volume, bus.busy, bus.active_id, bus.done,
                         x.div, x.vol, x.busy, x.aid, x.done);
            end
            if (x.done) $display("edge=%0d done id=%0d", x.edge_no, x.aid);
        end
    end

    initial begin
        logic [3:0] r;
        logic       m;
        logic       rs;
        bus.req  = 4'd0;
        bus.mute = 1'b0;

        // Reset, then a long idle stretch.
        drive(4'd0, 1'b0, 1'b1);
        drive(4'd0, 1'b0, 1'b1);
        idle(100, 1'b0);

        // Single beep.
        drive(4'b0001, 1'b0, 1'b0);
        idle(40, 1'b0);

        // Finish jingle with a mute window.
        drive(4'b1000, 1'b0, 1'b0);
        idle(49, 1'b0);
        idle(11, 1'b1);
        idle(110, 1'b0);

        // Beep preempted by go; a later beep request is dropped.
        drive(4'b0001, 1'b0, 1'b0);
        idle(4, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        idle(30, 1'b0);
        drive(4'b0001, 1'b0, 1'b0);
        idle(100, 1'b0);

        // Simultaneous requests pick pause; re-trigger restarts it.
        drive(4'b0110, 1'b0, 1'b0);
        idle(30, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        idle(60, 1'b0);

        // Reset mid-finish, then a normal beep.
        drive(4'b1000, 1'b0, 1'b0);
        idle(70, 1'b0);
        drive(4'd0, 1'b0, 1'b1);
        drive(4'b0001, 1'b0, 1'b0);
        idle(40, 1'b0);

        // Random requests, mute and occasional reset.
        m = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            rs = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) m = ~m;
            drive(r, m, rs);
        end
        idle(5, 1'b0);

        // Scoreboard must be drained within a bounded number of edges.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sound-effect scheduler that owns the single tone generator path (note divider and volume feeding the note generator and speaker controller) and shares it between four game-event requesters. It plays short fixed tone sequences from an internal effect ROM: countdown beep, GO, pause chirp and finish jingle. It arbitrates by fixed priority with preemption. It sits between the game state encoder and the note generator, and replaces ad-hoc per-state tone selection.

## Interface
- TICK_CYCLES, 5_000_000, clk cycles per sequencer tick (50 ms at 100 MHz); must be ≥ 2
- DIV_W, 22, width of the note divider output
- clk  input  1  system clock, 100 MHz
- rst  input  1  reset; one clock; reset is synchronous and active-high
- req  input  4  one-cycle request pulses, one bit per effect ID: 0 = beep, 1 = go, 2 = pause, 3 = finish
- mute  input  1  level; forces volume to 0 while high; sequencing continues unaffected
- note_div  output  DIV_W  divider to note generator; 22'h3FFFFF when silent
- volume  output  3  volume to note generator; 0 when silent
- busy  output  1  high while an effect is playing
- active_id  output  2  ID of the playing effect; holds its last value when idle
- done  output  1  one-cycle pulse when an effect completes naturally

## Operation
- States: IDLE and PLAY. Counters:
  - cyc_cnt, 0..TICK_CYCLES-1
  - tick_cnt, ticks remaining in the current step
  - step_idx, 0..3
- Effect ROM. Each step is (div, vol, ticks); MUTE is div 22'h3FFFFF with vol 0.
  - ID0 beep: (113636, 4, 3). One step.
  - ID1 go: (56818, 4, 12). One step.
  - ID2 pause: (75757, 3, 2), MUTE 1, (75757, 3, 2). Three steps.
  - ID3 finish: (95419, 5, 4), (75757, 5, 4), (63775, 5, 8). Three steps.
- Arbitration:
  - Candidate = highest set bit of req.
  - IDLE: any req starts the candidate at step 0.
  - PLAY: if candidate ID ≥ active_id, the current effect is aborted and the candidate starts from step 0. This covers both higher priority and a re-trigger of the same ID.
  - PLAY: if candidate ID < active_id, the request is dropped. Nothing is queued.
- Step sequencing:
  - cyc_cnt wraps at TICK_CYCLES-1.
  - tick_cnt decrements on each wrap.
  - When tick_cnt would reach 0, step_idx advances and the next step's ticks are loaded.
  - After the last step: return to IDLE, pulse done, drive MUTE.
- An aborted effect produces no done pulse.
- Outputs are registered. In PLAY, note_div and volume equal the ROM step, except volume is 0 when mute is high.
- The ROM is combinational and indexed by {active_id, step_idx}. Unused slots are MUTE with 1 tick and are never reached.

## Timing
- Reset values: note_div = 22'h3FFFFF, volume = 0, busy = 0, active_id = 0, done = 0. All counters are 0 and the state is IDLE.
- rst has priority over req in the same cycle. Reset mid-effect silences the output on the next edge.
- Start/preempt latency: req sampled high at edge N gives new note_div, volume, active_id and busy = 1 valid after edge N. cyc_cnt restarts at 0 on that edge.
- Step k holds its output for exactly ticks_k × TICK_CYCLES cycles.
- An effect of total T ticks started at edge N:
  - Last tone cycle ends at edge N + T·TICK_CYCLES.
  - After that edge: busy = 0, done = 1 for one cycle, outputs = MUTE.
- A req arriving on the completion edge is treated as an IDLE start. done still pulses for the completed effect, and busy stays 1.
- mute acts on volume from the next edge. note_div is unaffected.
- Multiple req bits in one cycle: only the highest is considered.

## Test plan
All scenarios use TICK_CYCLES = 10.
- Reset then idle: outputs 3FFFFF/0, busy 0, done 0 for 100 cycles with req = 0.
- req = 4'b0001 at edge N: note_div 113636, vol 4, busy 1 from N+1 through edge N+30. After edge N+30: done pulse, busy 0, 3FFFFF/0.
- Finish effect: req[3] → 95419 for 40 cycles, 75757 for 40, 63775 for 80, then done. mute high during cycles 50–60 → volume 0 there, note_div unchanged, total length still 160.
- Preemption: beep playing, req[1] at cycle 5 → note_div 56818 from the next cycle, active_id 1, go lasts 120 cycles, exactly one done. Beep request during go → dropped, no change.
- Simultaneous req = 4'b0110 → pause plays: 75757 for 20 cycles, MUTE for 10 with busy still 1, 75757 for 20. Re-trigger req[2] mid-sequence → restart at step 0.
- Reset asserted mid-finish → next cycle all outputs at reset values, no done; a following req[0] starts normally.
